// File: rtl/sal_rw_sched.sv
// sal_rw_sched: read/write turnaround scheduler for the DDR column-command path.
// Grants are combinational from registered state/counters and the live requests;
// counters and state advance at the next clock edge.
module sal_rw_sched #(
  parameter int WR_HI_WM     = 6,
  parameter int WR_LO_WM     = 2,
  parameter int MAX_WR_BATCH = 8,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       t_ccd_i,
  input  logic [3:0]       t_rtw_i,
  input  logic [3:0]       t_wtr_i,
  input  logic             rd_req_i,
  input  logic             wr_req_i,
  input  logic [CNT_W-1:0] wr_pend_cnt_i,
  output logic             rd_gnt_o,
  output logic             wr_gnt_o,
  output logic             wr_mode_o
);

  localparam int BW = $clog2(MAX_WR_BATCH + 1);
  localparam logic [CNT_W-1:0] HI_WM  = CNT_W'(WR_HI_WM);
  localparam logic [CNT_W-1:0] LO_WM  = CNT_W'(WR_LO_WM);
  localparam logic [BW-1:0]    BATCH_MAX = BW'(MAX_WR_BATCH);

  typedef enum logic [1:0] {S_READ, S_WR_TURN, S_WRITE, S_RD_TURN} state_e;

  state_e        state_q, state_d;
  logic [3:0]    ccd_q, rtw_q, wtr_q;
  logic [BW-1:0] batch_q;
  logic          rd_gnt, wr_gnt;
  logic          sw_w, sw_r;
  logic [3:0]    ccd_ld, rtw_ld, wtr_ld;

  // A programmed spacing of 0 behaves like 1, so the reload value is max(t,1)-1.
  assign ccd_ld = (t_ccd_i == 4'd0) ? 4'd0 : t_ccd_i - 4'd1;
  assign rtw_ld = (t_rtw_i == 4'd0) ? 4'd0 : t_rtw_i - 4'd1;
  assign wtr_ld = (t_wtr_i == 4'd0) ? 4'd0 : t_wtr_i - 4'd1;

  // Switch conditions: drain writes at high watermark (or when no read waits);
  // yield to a waiting read when writes run low or the batch is exhausted.
  assign sw_w = wr_req_i & ((wr_pend_cnt_i >= HI_WM) | ~rd_req_i);
  assign sw_r = rd_req_i & (~wr_req_i | (wr_pend_cnt_i <= LO_WM) | (batch_q == BATCH_MAX));

  // Next-state and grant decision; a switching cycle never grants.
  always_comb begin
    state_d = state_q;
    rd_gnt  = 1'b0;
    wr_gnt  = 1'b0;
    case (state_q)
      S_READ: begin
        if (sw_w) state_d = S_WR_TURN;
        else      rd_gnt  = rd_req_i & (ccd_q == 4'd0);
      end
      S_WR_TURN: begin
        if (rtw_q == 4'd0 && ccd_q == 4'd0) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (sw_r) state_d = S_RD_TURN;
        else      wr_gnt  = wr_req_i & (ccd_q == 4'd0);
      end
      S_RD_TURN: begin
        if (wtr_q == 4'd0 && ccd_q == 4'd0) state_d = S_READ;
      end
      default: state_d = S_READ;
    endcase
    // Reset kills any grant in the cycle it is asserted.
    if (rst) begin
      rd_gnt = 1'b0;
      wr_gnt = 1'b0;
    end
  end

  assign rd_gnt_o  = rd_gnt;
  assign wr_gnt_o  = wr_gnt;
  assign wr_mode_o = ~rst & ((state_q == S_WR_TURN) | (state_q == S_WRITE));

  // State and spacing counters; counters reload on grants and otherwise count down to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_READ;
      ccd_q   <= '0;
      rtw_q   <= '0;
      wtr_q   <= '0;
      batch_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd_gnt || wr_gnt)  ccd_q <= ccd_ld;
      else if (ccd_q != 4'd0) ccd_q <= ccd_q - 4'd1;
      if (rd_gnt)            rtw_q <= rtw_ld;
      else if (rtw_q != 4'd0) rtw_q <= rtw_q - 4'd1;
      if (wr_gnt)            wtr_q <= wtr_ld;
      else if (wtr_q != 4'd0) wtr_q <= wtr_q - 4'd1;
      if (state_q != S_WRITE && state_d == S_WRITE) batch_q <= '0;
      else if (wr_gnt && batch_q != BATCH_MAX)      batch_q <= batch_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_sal_rw_sched.sv
// Bench for sal_rw_sched: directed scenarios plus randomized traffic, all
// checked against a timestamp-based reference model of the scheduling rules.
module tb_sal_rw_sched;
  localparam int HI = 6, LO = 2, MAXB = 8, CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    t_ccd = 4'd1, t_rtw = 4'd1, t_wtr = 4'd1;
  logic          rd_req = 1'b0, wr_req = 1'b0;
  logic [CW-1:0] pend = '0;
  logic          rd_gnt, wr_gnt, wr_mode;

  always #5 clk = ~clk;

  sal_rw_sched #(.WR_HI_WM(HI), .WR_LO_WM(LO), .MAX_WR_BATCH(MAXB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .t_ccd_i(t_ccd), .t_rtw_i(t_rtw), .t_wtr_i(t_wtr),
    .rd_req_i(rd_req), .wr_req_i(wr_req), .wr_pend_cnt_i(pend),
    .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt), .wr_mode_o(wr_mode));

  int n_vec = 0, n_err = 0;
  // model: mode 0 read, 1 turning to write, 2 write, 3 turning to read
  int mode = 0, batch = 0, now = 0;
  int last_rd = -1000, last_wr = -1000, last_any = -1000;
  int e_rd, e_wr, e_mode, nxt;
  logic o_rd, o_wr, o_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, now);
    end
  endtask

  function automatic int tq(input logic [3:0] t);
    return (t == 4'd0) ? 1 : int'(t);
  endfunction

  // One clock: drive inputs, predict, compare, then advance the model at the edge.
  task automatic cyc(input logic r, input logic rq, input logic wq, input int pc);
    bit ccd_ok;
    @(negedge clk);
    rst = r; rd_req = rq; wr_req = wq; pend = pc[CW-1:0];
    #1;
    e_rd = 0; e_wr = 0; nxt = mode;
    ccd_ok = (now - last_any) >= tq(t_ccd);
    if (!r) begin
      case (mode)
        0: if (wq && (pc >= HI || !rq)) nxt = 1; else e_rd = int'(rq && ccd_ok);
        1: if ((now - last_rd) >= tq(t_rtw) && ccd_ok) nxt = 2;
        2: if (rq && (!wq || pc <= LO || batch == MAXB)) nxt = 3; else e_wr = int'(wq && ccd_ok);
        default: if ((now - last_wr) >= tq(t_wtr) && ccd_ok) nxt = 0;
      endcase
    end
    e_mode = int'(!r && (mode == 1 || mode == 2));
    o_rd = rd_gnt; o_wr = wr_gnt; o_mode = wr_mode;
    chk("rd_gnt", 32'(o_rd), 32'(e_rd));
    chk("wr_gnt", 32'(o_wr), 32'(e_wr));
    chk("wr_mode", 32'(o_mode), 32'(e_mode));
    chk("excl", 32'(o_rd & o_wr), 32'd0);
    @(posedge clk);
    if (r) begin
      mode = 0; batch = 0; last_rd = -1000; last_wr = -1000; last_any = -1000;
    end else begin
      if (e_rd != 0) begin last_rd = now; last_any = now; end
      if (e_wr != 0) begin last_wr = now; last_any = now; if (batch < MAXB) batch++; end
      if (nxt == 2 && mode != 2) batch = 0;
      mode = nxt;
    end
    now++;
  endtask

  task automatic set_t(input int c, input int rtw, input int wtr);
    t_ccd = 4'(c); t_rtw = 4'(rtw); t_wtr = 4'(wtr);
  endtask

  initial begin
    int cnt;
    bit rq_h, wq_h, r;

    // Reset with a read pending: no grants, read grant right after release.
    set_t(4, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("rst_release_rd", 32'(o_rd), 32'd1);

    // Read stream at t_ccd=4.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      cyc(0, 1, 0, 0);
      chk("stream_rd", 32'(o_rd), 32'(i % 4 == 0));
      chk("stream_mode", 32'(o_mode), 32'd0);
    end

    // High-watermark drain: read at 0, write forced at 1, first write grant at 7.
    set_t(2, 6, 1);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("hwm_rd0", 32'(o_rd), 32'd1);
    for (int i = 1; i < 9; i++) begin
      cyc(0, 0, 1, 6);
      chk("hwm_wr", 32'(o_wr), 32'(i == 7));
      if (i == 2) chk("hwm_turn_mode", 32'(o_mode), 32'd1);
    end

    // Low-watermark yield: writes at 2,3; switch at 4 (count 2); read at 9.
    set_t(1, 1, 5);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 4);
    cyc(0, 0, 1, 4);
    cyc(0, 1, 1, 4); chk("lwm_wr2", 32'(o_wr), 32'd1);
    cyc(0, 1, 1, 3); chk("lwm_wr3", 32'(o_wr), 32'd1);
    cyc(0, 1, 1, 2); chk("lwm_sw", 32'(o_wr), 32'd0);
    for (int i = 5; i < 10; i++) begin
      cyc(0, 1, 1, 2);
      chk("lwm_rd", 32'(o_rd), 32'(i == 9));
    end

    // Batch limit: exactly eight writes before yielding to the read.
    set_t(1, 1, 1);
    cyc(1, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 13; i++) begin
      cyc(0, 1, 1, 7);
      cnt += int'(o_wr);
      if (i == 10) chk("batch_sw_mode", 32'(o_mode), 32'd1);
      if (i == 11) chk("batch_rdturn_mode", 32'(o_mode), 32'd0);
    end
    chk("batch_count", 32'(cnt), 32'd8);

    // Reset during WR_TURN returns to READ with counters cleared.
    set_t(8, 15, 1);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 6);
    cyc(0, 0, 1, 6); chk("midrst_turn", 32'(o_mode), 32'd1);
    cyc(1, 0, 1, 6);
    cyc(0, 1, 0, 0);
    chk("midrst_rd", 32'(o_rd), 32'd1);
    chk("midrst_mode", 32'(o_mode), 32'd0);

    // Idle in WRITE: stays in write mode with no grants.
    set_t(1, 1, 1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0); chk("idle_wr_gnt", 32'(o_wr), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0);
      cnt += int'(o_rd) + int'(o_wr);
      chk("idle_mode", 32'(o_mode), 32'd1);
    end
    chk("idle_gnts", 32'(cnt), 32'd0);

    // Randomized traffic; requests held until granted, timings change only under reset.
    rq_h = 0; wq_h = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom % 150) == 0;
      if (r) set_t($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      if (!rq_h) rq_h = ($urandom % 3) == 0;
      if (!wq_h) wq_h = ($urandom % 3) == 0;
      cyc(r, rq_h, wq_h, (($urandom % 8) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9));
      if (r) begin rq_h = 0; wq_h = 0; end
      if (e_rd != 0) rq_h = 0;
      if (e_wr != 0) wq_h = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sal_rw_sched.md
# sal_rw_sched

Read/write turnaround scheduler for the DDR column-command path. It decides, per cycle, whether a pending column read or column write may issue. It enforces tCCD, read-to-write (tRTW) and write-to-read (tWTR) spacing, and batches writes using watermarks on the count of write requests that already hold full data. Its write grant is the pulse that launches the DFI write-enable shift chain in the write controller; its read grant feeds the read path.

## Interface
Parameters:
- WR_HI_WM, 6: pending-write count at or above which read mode is forced to drain writes.
- WR_LO_WM, 2: pending-write count at or below which write mode yields to a waiting read.
- MAX_WR_BATCH, 8: maximum writes granted per write-mode visit while a read is waiting.
- CNT_W, 5: width of the pending-write count input.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset. One clock; reset is synchronous and active-high.
- t_ccd_i, input, 4: column-to-column spacing in cycles. Quasi-static. 0 is treated as 1.
- t_rtw_i, input, 4: read-grant to write-grant spacing. Quasi-static. 0 is treated as 1.
- t_wtr_i, input, 4: write-grant to read-grant spacing. Quasi-static. 0 is treated as 1.
- rd_req_i, input, 1: a read column command is ready. Held until granted.
- wr_req_i, input, 1: a write column command with complete data is ready. Held until granted.
- wr_pend_cnt_i, input, CNT_W: number of buffered write requests with full data.
- rd_gnt_o, output, 1: one-cycle read issue pulse.
- wr_gnt_o, output, 1: one-cycle write issue pulse. Drives the write-enable launch.
- wr_mode_o, output, 1: 1 in WR_TURN or WRITE, 0 otherwise.

## Operation
- **State machine** (one-hot or encoded): READ, WR_TURN, WRITE, RD_TURN. Reset state is READ.
- **Counters** all decrement by 1 per cycle and saturate at 0:
  - ccd_cnt loads max(t_ccd_i,1)-1 on any grant.
  - rtw_cnt loads max(t_rtw_i,1)-1 on rd_gnt_o.
  - wtr_cnt loads max(t_wtr_i,1)-1 on wr_gnt_o.
  - batch_cnt is cleared on entry to WRITE and increments on wr_gnt_o, saturating at MAX_WR_BATCH.
- **READ**:
  - sw_w = wr_req_i & (wr_pend_cnt_i >= WR_HI_WM | ~rd_req_i).
  - If sw_w: go to WR_TURN and issue no grant this cycle.
  - Else rd_gnt_o = rd_req_i & (ccd_cnt==0).
- **WR_TURN**: no grants. Go to WRITE when rtw_cnt==0 & ccd_cnt==0.
- **WRITE**:
  - sw_r = rd_req_i & (~wr_req_i | wr_pend_cnt_i <= WR_LO_WM | batch_cnt==MAX_WR_BATCH).
  - If sw_r: go to RD_TURN and issue no grant this cycle.
  - Else wr_gnt_o = wr_req_i & (ccd_cnt==0).
- **RD_TURN**: no grants. Go to READ when wtr_cnt==0 & ccd_cnt==0.
- **Idle**: with no requests, the FSM holds its current state. There is no idle return to READ.
- **Exclusivity**: rd_gnt_o and wr_gnt_o are never high in the same cycle.
- **Comparisons**: watermark comparisons are unsigned, at CNT_W bits.

## Timing
- **Reset values**: all outputs 0; state READ; all counters 0.
- **Mid-operation reset**: reset asserted mid-operation drops any grant in that cycle. It also drops any turnaround in progress.
- **Grant latency**: grants are combinational from registered state and counters plus the current request. A grant appears in the same cycle the request is seen eligible. Counters and state update at the next edge.
- **Same-mode spacing**: back-to-back grants are exactly t_ccd cycles apart when requests are held.
- **Read-to-write spacing**: the minimum gap from a read grant to a write grant is max(t_rtw, t_ccd)+1 cycles. This is one extra cycle for the WR_TURN to WRITE transition.
- **Write-to-read spacing**: the minimum gap from a write grant to a read grant is max(t_wtr, t_ccd)+1 cycles, by the same rule.
- **Switch cycle**: the cycle in which a switch condition is true never issues a grant, even if ccd_cnt==0.
- **Request withdrawal**: a request deasserted during a turnaround does not abort it. The FSM completes the turnaround and then re-evaluates in the new mode.

## Test plan
- **Reset**: reset for 3 cycles with rd_req_i=1 -> no grants, wr_mode_o=0. After release, rd_gnt_o is high on the first cycle.
- **Read stream**: t_ccd=4, rd_req_i held, wr_pend_cnt=0 -> rd_gnt_o at cycles 0,4,8,12. wr_mode_o stays 0.
- **High-watermark drain**: t_ccd=2, t_rtw=6, rd grant at cycle 0, then wr_pend_cnt=6 and wr_req at cycle 1 -> WR_TURN at cycle 2; first wr_gnt_o at cycle 7.
- **Low-watermark yield**: in WRITE with rd_req=1, pend count falling 4,3,2 -> the switch to RD_TURN happens on the cycle the count reads 2. With t_wtr=5, rd_gnt_o follows 6 cycles after the last wr_gnt_o.
- **Batch limit**: pend count held at 7, both requests held, t_ccd=1 -> exactly 8 wr_gnt_o pulses, then RD_TURN.
- **Mid-turnaround reset and idle**:
  - Reset asserted in WR_TURN -> next cycle is READ with all counters 0.
  - Both requests low for 20 cycles -> no state change and no grants.
